sequence_generator_1101: RTL and testbench

SEQUENCE_GENERATOR_1101 -- requirements
Module: sequence_generator_1101

---
 rtl/sequence_generator_1101.sv | 122 ++++++++++++
 tb/tb_sequence_generator_1101.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sequence_generator_1101.sv
// Burst generator for the serial pattern 1101, N patterns per burst, overlapped or not.
// Optional build macro SEQGEN_GAP_EN inserts a 0 gap bit between non-overlapped patterns.
module sequence_generator_1101 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mode,
   input  logic [3:0] count,
   output logic       data,
   output logic       valid,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      B0   = 3'd1,
      B1   = 3'd2,
      B2   = 3'd3,
      B3   = 3'd4,
`ifdef SEQGEN_GAP_EN
      GAP  = 3'd5,
`endif
      DONE = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] remaining_q, remaining_d;
   logic       mode_q, mode_d;
   logic       data_q, data_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   // Outputs are decoded from the next state so they appear registered alongside it.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      mode_d      = mode_q;
      data_d      = 1'b0;
      valid_d     = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && (count != 4'd0)) begin
               mode_d      = mode;
               remaining_d = count;
               state_d     = B0;
            end
         end
         B0: state_d = B1;
         B1: state_d = B2;
         B2: state_d = B3;
         B3: begin
            if (remaining_q > 4'd1) begin
               remaining_d = remaining_q - 4'd1;
`ifdef SEQGEN_GAP_EN
               state_d     = mode_q ? B1 : GAP;
`else
               state_d     = mode_q ? B1 : B0;
`endif
            end else begin
               remaining_d = 4'd0;
               state_d     = DONE;
            end
         end
`ifdef SEQGEN_GAP_EN
         GAP: state_d = B0;
`endif
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      case (state_d)
         B0, B1, B3: begin
            data_d  = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
         B2: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
`ifdef SEQGEN_GAP_EN
         GAP: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
`endif
         DONE: done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         remaining_q <= 4'd0;
         mode_q      <= 1'b0;
         data_q      <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         mode_q      <= mode_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator_1101.sv
// Table-driven bench for sequence_generator_1101 with hand-computed bursts plus an async reset sequence.
// Expected mode=0 streams follow SEQGEN_GAP_EN when the bench is built with it.
module tb_sequence_generator_1101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic [3:0] count;
   logic       data;
   logic       valid;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       start;
      logic       mode;
      logic [3:0] count;
      logic       expData;
      logic       expValid;
      logic       expBusy;
      logic       expDone;
   } vector_t;

   vector_t vecs[$];

`ifdef SEQGEN_GAP_EN
   localparam logic [31:0] M0N2_BITS = 32'b110101101;
   localparam int          M0N2_LEN  = 9;
`else
   localparam logic [31:0] M0N2_BITS = 32'b11011101;
   localparam int          M0N2_LEN  = 8;
`endif

   sequence_generator_1101 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .count (count),
      .data  (data),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic applyStimulus(input vector_t v);
      start = v.start;
      mode  = v.mode;
      count = v.count;
   endtask

   task automatic addRow(input string tag, input logic s, input logic m, input logic [3:0] n,
                         input logic d, input logic v, input logic b, input logic dn);
      vector_t r;
      r.tag = tag; r.start = s; r.mode = m; r.count = n;
      r.expData = d; r.expValid = v; r.expBusy = b; r.expDone = dn;
      vecs.push_back(r);
   endtask

   // One burst: a start row, one row per bit, the done row, then an idle row that retries start in DONE.
   task automatic addBurst(input string tag, input logic m, input logic [3:0] n,
                           input logic [31:0] bits, input int nbits, input int glitchAt);
      for (int i = 0; i < nbits; i++) begin
         if (i == glitchAt)
            addRow(tag, 1'b1, ~m, 4'd15, bits[nbits-1-i], 1'b1, 1'b1, 1'b0);
         else
            addRow(tag, (i == 0), m, n, bits[nbits-1-i], 1'b1, 1'b1, 1'b0);
      end
      addRow(tag, 1'b0, m, n, 1'b0, 1'b0, 1'b0, 1'b1);
      addRow(tag, 1'b1, m, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic runVectors();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         @(negedge clk);
         checkOutput({vecs[i].tag, ".data"},  i, data,  vecs[i].expData);
         checkOutput({vecs[i].tag, ".valid"}, i, valid, vecs[i].expValid);
         checkOutput({vecs[i].tag, ".busy"},  i, busy,  vecs[i].expBusy);
         checkOutput({vecs[i].tag, ".done"},  i, done,  vecs[i].expDone);
      end
      vecs.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      count = 4'd0;

      #12;
      checkOutput("rst.data",  0, data,  1'b0);
      checkOutput("rst.valid", 0, valid, 1'b0);
      checkOutput("rst.busy",  0, busy,  1'b0);
      checkOutput("rst.done",  0, done,  1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      addBurst("m0n2", 1'b0, 4'd2, M0N2_BITS, M0N2_LEN, -1);
      addBurst("m1n3", 1'b1, 4'd3, 32'b1101101101, 10, -1);
      for (int i = 0; i < 5; i++)
         addRow("zero", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      addBurst("glitch", 1'b0, 4'd2, M0N2_BITS, M0N2_LEN, 3);
      addBurst("m1n2", 1'b1, 4'd2, 32'b1101101, 7, -1);
      addBurst("m0n1", 1'b0, 4'd1, 32'b1101, 4, -1);
      runVectors();

      // Asynchronous reset while bit 3 is on the line.
      start = 1'b1; mode = 1'b0; count = 4'd2;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("midrst.pre.valid", 0, valid, 1'b1);
      checkOutput("midrst.pre.data",  0, data,  1'b0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst.data",  0, data,  1'b0);
      checkOutput("midrst.valid", 0, valid, 1'b0);
      checkOutput("midrst.busy",  0, busy,  1'b0);
      checkOutput("midrst.done",  0, done,  1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst.hold.done", 1, done, 1'b0);
      checkOutput("midrst.hold.busy", 1, busy, 1'b0);
      rst_n = 1'b1;

      addBurst("postrst", 1'b0, 4'd1, 32'b1101, 4, -1);
      runVectors();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
